// File: rtl/clk_en_pkg.sv
// Shared types and sizing helpers for the clock-enable generator.
// Imported by the interface, the channel slice and the top.
package clk_en_pkg;

   typedef enum logic [1:0] {
      WAIT_LOCK,
      SETTLE,
      RUN
   } state_t;

   localparam int DEF_DIV_W = 8;

   function automatic int settle_w(input int dly);
      return (dly < 1) ? 1 : $clog2(dly + 1);
   endfunction

endpackage

// File: rtl/clk_en_gen_if.sv
// Control/status bundle between the strobe generator and its user.
// The master drives lock, divisors and enables; the slave returns strobes.
interface clk_en_gen_if
   import clk_en_pkg::*;
#(
   parameter int NUM_CH = 3,
   parameter int DIV_W  = DEF_DIV_W,
   parameter int LOST_W = 8
);
   logic                    pll_locked_i;
   logic [NUM_CH*DIV_W-1:0] div_i;
   logic [NUM_CH-1:0]       ch_en_i;
   logic                    realign_i;
   logic [NUM_CH-1:0]       stb_o;
   logic                    ready_o;
   logic [LOST_W-1:0]       lost_cnt_o;

   modport master (
      output pll_locked_i, div_i, ch_en_i, realign_i,
      input  stb_o, ready_o, lost_cnt_o
   );

   modport slave (
      input  pll_locked_i, div_i, ch_en_i, realign_i,
      output stb_o, ready_o, lost_cnt_o
   );
endinterface

// File: rtl/clk_en_chan.sv
// One programmable clock-enable channel: period = div+1 cycles.
// The divisor is captured only at load or terminal count.
module clk_en_chan
   import clk_en_pkg::*;
#(
   parameter int DIV_W = DEF_DIV_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             run,
   input  logic             load,
   input  logic             en,
   input  logic [DIV_W-1:0] div,
   output logic             stb
);
   logic [DIV_W-1:0] shadow;
   logic [DIV_W-1:0] cnt;

   // cnt climbs to the captured shadow, so a mid-period div write waits
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shadow <= '0;
         cnt    <= '0;
         stb    <= 1'b0;
      end else if (load) begin
         shadow <= div;
         cnt    <= '0;
         stb    <= 1'b0;
      end else if (run && en) begin
         if (cnt == shadow) begin
            stb    <= 1'b1;
            shadow <= div;
            cnt    <= '0;
         end else begin
            stb <= 1'b0;
            cnt <= cnt + DIV_W'(1);
         end
      end else begin
         stb <= 1'b0;
      end
   end
endmodule

// File: rtl/clk_en_gen.sv
// Lock-gated multi-channel clock-enable generator.
// Holds lock sync, settle FSM, lock-loss counter and the channel array.
module clk_en_gen
   import clk_en_pkg::*;
#(
   parameter int NUM_CH   = 3,
   parameter int DIV_W    = DEF_DIV_W,
   parameter int LOCK_DLY = 1024,
   parameter int LOST_W   = 8
) (
   input logic   clk,
   input logic   rst_n,
   clk_en_gen_if.slave bus
);
   localparam int SW = settle_w(LOCK_DLY);
   localparam logic [SW-1:0] DLY = SW'(LOCK_DLY);

   state_t            state;
   logic [1:0]        sync_q;
   logic              lk_s;
   logic [SW-1:0]     settle_q;
   logic [LOST_W-1:0] lost_q;
   logic              ready_q;
   logic [NUM_CH-1:0] en_q;
   logic [NUM_CH-1:0] load;
   logic [NUM_CH-1:0] stb;
   logic              run;
   logic              enter_run;
   logic              ld_all;

   assign lk_s = sync_q[1];
   assign run  = (state == RUN) && lk_s;

   assign enter_run = (state == SETTLE) && lk_s
                   && (settle_q == DLY);
   assign ld_all = enter_run || (run && bus.realign_i);
   assign load = {NUM_CH{ld_all}}
               | ({NUM_CH{run}} & bus.ch_en_i & ~en_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= 2'b00;
      end else begin
         sync_q <= {sync_q[0], bus.pll_locked_i};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= WAIT_LOCK;
         settle_q <= '0;
         lost_q   <= '0;
         ready_q  <= 1'b0;
         en_q     <= '0;
      end else begin
         en_q <= bus.ch_en_i;
         unique case (state)
            WAIT_LOCK: begin
               if (lk_s) begin
                  state    <= SETTLE;
                  settle_q <= '0;
               end
            end
            SETTLE: begin
               if (!lk_s) begin
                  state <= WAIT_LOCK;
               end else if (settle_q == DLY) begin
                  state   <= RUN;
                  ready_q <= 1'b1;
               end else begin
                  settle_q <= settle_q + SW'(1);
               end
            end
            RUN: begin
               if (!lk_s) begin
                  state   <= WAIT_LOCK;
                  ready_q <= 1'b0;
                  if (~&lost_q) lost_q <= lost_q + LOST_W'(1);
               end
            end
            default: begin
               state   <= WAIT_LOCK;
               ready_q <= 1'b0;
            end
         endcase
      end
   end

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      clk_en_chan #(
         .DIV_W (DIV_W)
      ) u_chan (
         .clk   (clk),
         .rst_n (rst_n),
         .run   (run),
         .load  (load[c]),
         .en    (bus.ch_en_i[c]),
         .div   (bus.div_i[c*DIV_W +: DIV_W]),
         .stb   (stb[c])
      );
   end

   assign bus.stb_o      = stb;
   assign bus.ready_o    = ready_q;
   assign bus.lost_cnt_o = lost_q;
endmodule

// File: tb/tb_clk_en_gen.sv
// Directed bench for clk_en_gen with a timeline-based reference model.
// Inputs change on negedge; outputs are compared on every negedge.
module tb_clk_en_gen;
   localparam int NUM_CH   = 3;
   localparam int DIV_W    = 8;
   localparam int LOCK_DLY = 16;
   localparam int LOST_W   = 8;
   localparam int LOST_MAX = (1 << LOST_W) - 1;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   clk_en_gen_if #(
      .NUM_CH (NUM_CH),
      .DIV_W  (DIV_W),
      .LOST_W (LOST_W)
   ) bus ();

   clk_en_gen #(
      .NUM_CH   (NUM_CH),
      .DIV_W    (DIV_W),
      .LOCK_DLY (LOCK_DLY),
      .LOST_W   (LOST_W)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input longint act,
                      input longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Reference model in absolute edge time: ready needs LOCK_DLY+2
   // consecutive synchronised-high samples; each channel keeps the
   // edge index of its next strobe.
   bit              m_p1 = 0;
   bit              m_p2 = 0;
   int              streak = 0;
   bit              m_ready = 0;
   int              m_lost = 0;
   bit [NUM_CH-1:0] m_stb = '0;
   bit [NUM_CH-1:0] en_prev = '0;
   longint          nxt [NUM_CH];
   longint          n = 0;

   always @(posedge clk or negedge rst_n) begin
      bit lk;
      bit rb;
      int d;
      if (!rst_n) begin
         m_p1 = 0;
         m_p2 = 0;
         streak = 0;
         m_ready = 0;
         m_lost = 0;
         m_stb = '0;
         en_prev = '0;
      end else begin
         lk = m_p2;
         m_p2 = m_p1;
         m_p1 = bus.pll_locked_i;
         rb = m_ready;
         streak = lk ? streak + 1 : 0;
         m_ready = (streak >= LOCK_DLY + 2);
         if (rb && !lk && m_lost < LOST_MAX) m_lost++;
         for (int c = 0; c < NUM_CH; c++) begin
            d = int'(bus.div_i[c*DIV_W +: DIV_W]);
            m_stb[c] = 0;
            if (!rb && m_ready) begin
               nxt[c] = n + d + 1;
            end else if (rb && m_ready) begin
               if (bus.realign_i ||
                   (bus.ch_en_i[c] && !en_prev[c])) begin
                  nxt[c] = n + d + 1;
               end else if (bus.ch_en_i[c] && n == nxt[c]) begin
                  m_stb[c] = 1;
                  nxt[c] = n + d + 1;
               end
            end
         end
         en_prev = bus.ch_en_i;
         n++;
      end
   end

   always @(negedge clk) begin
      chk("ready_o", bus.ready_o, m_ready);
      chk("lost_cnt_o", bus.lost_cnt_o, m_lost);
      chk("stb_o", bus.stb_o, m_stb);
   end

   task automatic set_div(input int c, input int v);
      bus.div_i[c*DIV_W +: DIV_W] = DIV_W'(v);
   endtask

   task automatic wait_rdy(input bit lvl, output int el);
      el = 0;
      do begin
         @(negedge clk);
         el++;
      end while (bus.ready_o !== lvl && el < 100);
      if (bus.ready_o !== lvl) chk("ready_timeout", el, -1);
   endtask

   task automatic wait_stb(input int c, output int el);
      el = 0;
      do begin
         @(negedge clk);
         el++;
      end while (!bus.stb_o[c] && el < 64);
      if (!bus.stb_o[c]) chk("stb_timeout", el, -1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int el;
      int k;
      int first [NUM_CH];
      int cnt [NUM_CH];
      logic [NUM_CH-1:0] seen;

      bus.pll_locked_i = 1'b0;
      bus.div_i = '0;
      bus.ch_en_i = '0;
      bus.realign_i = 1'b0;

      repeat (3) @(negedge clk);
      chk("rst_ready", bus.ready_o, 0);
      chk("rst_stb", bus.stb_o, 0);
      chk("rst_lost", bus.lost_cnt_o, 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // lock rises: 2 sync + 1 enter + 16 count + 1 -> ready
      set_div(0, 0);
      set_div(1, 1);
      set_div(2, 4);
      bus.ch_en_i = 3'b111;
      bus.pll_locked_i = 1'b1;
      seen = '0;
      k = 0;
      while (!bus.ready_o && k < 100) begin
         @(negedge clk);
         k++;
         if (!bus.ready_o) seen |= bus.stb_o;
      end
      chk("ready_latency", k, 20);
      chk("stb_before_ready", seen, 0);

      for (int c = 0; c < NUM_CH; c++) begin
         first[c] = -1;
         cnt[c] = 0;
      end
      for (int i = 1; i <= 1000; i++) begin
         @(negedge clk);
         for (int c = 0; c < NUM_CH; c++) begin
            if (bus.stb_o[c]) begin
               cnt[c]++;
               if (first[c] < 0) first[c] = i;
            end
         end
      end
      chk("first_ch0", first[0], 1);
      chk("first_ch1", first[1], 2);
      chk("first_ch2", first[2], 5);
      chk("count_ch0", cnt[0], 1000);
      chk("count_ch1", cnt[1], 500);
      chk("count_ch2", cnt[2], 200);

      // divisor write mid-period only applies after the next strobe
      bus.ch_en_i = 3'b001;
      set_div(0, 9);
      wait_stb(0, el);
      wait_stb(0, el);
      chk("period_div9", el, 10);
      repeat (4) @(negedge clk);
      set_div(0, 2);
      wait_stb(0, el);
      chk("glitch_hold", 4 + el, 10);
      wait_stb(0, el);
      chk("period_div2_a", el, 3);
      wait_stb(0, el);
      chk("period_div2_b", el, 3);

      // ch1 enabled one cycle after a ch0 strobe lags ch0 by 2
      set_div(0, 3);
      set_div(1, 3);
      wait_stb(0, el);
      wait_stb(0, el);
      chk("period_div3", el, 4);
      @(negedge clk);
      bus.ch_en_i = 3'b011;
      wait_stb(1, el);
      chk("enable_first", el, 5);
      chk("offset_pattern", bus.stb_o, 3'b010);
      @(negedge clk);
      bus.realign_i = 1'b1;
      @(negedge clk);
      bus.realign_i = 1'b0;
      k = 1;
      while (bus.stb_o == '0 && k < 32) begin
         @(negedge clk);
         k++;
      end
      chk("realign_delay", k, 5);
      chk("realign_pattern", bus.stb_o, 3'b011);
      for (int i = 0; i < 3; i++) begin
         repeat (4) @(negedge clk);
         chk("aligned", bus.stb_o, 3'b011);
      end

      // lock loss in RUN
      bus.ch_en_i = 3'b111;
      repeat (7) @(negedge clk);
      bus.pll_locked_i = 1'b0;
      wait_rdy(1'b0, el);
      chk("loss_latency", el, 3);
      chk("loss_stb", bus.stb_o, 0);
      chk("loss_count", bus.lost_cnt_o, 1);
      bus.pll_locked_i = 1'b1;
      wait_rdy(1'b1, el);
      chk("relock_latency", el, 20);

      for (int i = 1; i < 300; i++) begin
         bus.pll_locked_i = 1'b0;
         wait_rdy(1'b0, el);
         bus.pll_locked_i = 1'b1;
         wait_rdy(1'b1, el);
      end
      chk("lost_saturate", bus.lost_cnt_o, 255);

      // asynchronous reset between edges while running
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("areset_ready", bus.ready_o, 0);
      chk("areset_stb", bus.stb_o, 0);
      chk("areset_lost", bus.lost_cnt_o, 0);
      @(negedge clk);
      rst_n = 1'b1;
      wait_rdy(1'b1, el);
      chk("post_reset_latency", el, 20);
      chk("post_reset_lost", bus.lost_cnt_o, 0);
      repeat (10) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end
endmodule

// File: doc/clk_en_gen.md
Name: clk_en_gen

Overview:
- Parametrised successor to the fixed three-output PLL wrapper.
- Runs off one PLL output clock and generates NUM_CH independent single-cycle clock-enable strobes.
- Each strobe's divide ratio is programmable at runtime, with glitch-free ratio changes.
- Gated by a synchronised PLL lock with a settle hold-off; all channels are phase-aligned on start or on request, and lock losses are counted.
- Downstream CPU, video and audio logic use the strobes instead of extra PLL outputs.

Parameters:
- NUM_CH, 3, number of enable channels (1..16).
- DIV_W, 8, width of each channel divisor; strobe period = div+1 cycles.
- LOCK_DLY, 1024, clk cycles lock must stay high before ready_o asserts (0 allowed).
- LOST_W, 8, width of the saturating lock-loss counter.

Ports:
- clk  in  1  system clock (PLL output).
- rst_n  in  1  asynchronous, active-low reset.
- pll_locked_i  in  1  PLL lock, asynchronous to clk.
- div_i  in  NUM_CH*DIV_W  divisor per channel; channel c at bits [c*DIV_W +: DIV_W].
- ch_en_i  in  NUM_CH  per-channel enable.
- realign_i  in  1  single-cycle pulse; re-phases all channels.
- stb_o  out  NUM_CH  clock-enable strobes, registered.
- ready_o  out  1  high while in RUN.
- lost_cnt_o  out  LOST_W  saturating count of lock losses seen in RUN.

Behaviour:
- Reset (rst_n low, async):
  - stb_o=0, ready_o=0, lost_cnt_o=0, lock synchroniser=0.
  - Channel counters and shadows=0; state=WAIT_LOCK.
- Lock synchroniser: 2-FF; lk_s is pll_locked_i delayed by 2 clk.
- State machine (WAIT_LOCK, SETTLE, RUN):
  - WAIT_LOCK: when lk_s=1, go to SETTLE and clear the settle counter.
  - SETTLE:
    - If lk_s=0, return to WAIT_LOCK.
    - Otherwise count up; when count==LOCK_DLY go to RUN. With LOCK_DLY=0, RUN is entered the cycle after entering SETTLE.
  - RUN:
    - If lk_s=0: go to WAIT_LOCK, ready_o=0 next cycle, stb_o=0 next cycle, lost_cnt_o += 1 (saturating at all-ones).
  - ready_o is registered: high exactly in cycles where state==RUN.
- Channel c, loading:
  - On the RUN-entry cycle, or on realign_i=1 in RUN, or on the ch_en_i[c] 0->1 edge in RUN: shadow<=div_i[c], cnt<=div_i[c], stb_o[c]<=0.
- Channel c, counting (RUN, ch_en_i[c]=1, no load):
  - cnt!=0: cnt<=cnt-1, stb_o[c]<=0.
  - cnt==0: stb_o[c]<=1; shadow<=div_i[c]; cnt<=div_i[c].
  - Divisor changes therefore take effect only at the terminal count; no runt or stretched periods.
- Timing:
  - Cycle 0 is the first cycle ready_o=1. The first strobe on a channel is high in cycle div+1; thereafter every div+1 cycles.
  - div=0: stb_o[c] is high every cycle from cycle 1.
- ch_en_i[c]=0: stb_o[c]=0 from the next cycle, counter frozen; re-enable behaves as a load.
- Simultaneous events:
  - Lock loss overrides realign_i and enable edges.
  - realign_i overrides the terminal-count reload.
  - realign_i outside RUN is ignored.
- All channels with equal div and a common load cycle stay phase-identical indefinitely.

Decomposition:
- Package clk_en_pkg holds:
  - state enum {WAIT_LOCK, SETTLE, RUN};
  - default DIV_W;
  - a localparam function for the settle counter width, clog2(LOCK_DLY+1).
- Sub-module clk_en_chan, one instance per channel via generate. Ports: clk, rst_n, run, load, en, div, stb. It holds the shadow, counter and strobe register.
- The top holds the synchroniser, FSM, settle counter and lost counter.

Test Plan:
- Reset/lock: LOCK_DLY=16, lock rises at t0 -> ready_o rises exactly 2+1+16+1 clk later (sync, enter SETTLE, count, RUN); stb_o=0 throughout.
- Ratios: div={0,1,4} -> periods 1,2,5 cycles; first strobes in cycles 1,2,5 after ready_o rises; 1000-cycle strobe counts = 1000,500,200.
- Glitch-free change: ch0 div 9->2 written mid-period (cnt=5) -> next strobe still 10 cycles after the previous one, then period 3.
- Realign: ch0 div=3, ch1 div=3, ch1 enabled 2 cycles later -> strobes offset by 2 cycles; realign_i pulse -> both strobe together 4 cycles after the pulse, then stay aligned.
- Lock loss: drop pll_locked_i in RUN -> ready_o and stb_o low 3 cycles later, lost_cnt_o=1; relock -> full SETTLE repeats. 300 drops with LOST_W=8 -> lost_cnt_o saturates at 255.
- Async reset mid-RUN: rst_n low between edges -> all outputs 0 immediately; after release, behaves like the reset/lock scenario and lost_cnt_o=0.
